// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage with hold buffer feeding the IF/ID registers
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] pc_if,
  output logic        pc_stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;
  state_t state, state_n;
  logic [31:0] req_pc, hold_pc, hold_inst, dlv_pc, dlv_inst;
  logic deliver;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = (imem_req && imem_ready) ? WAIT : IDLE;
      WAIT: state_n = flush ? (imem_rvalid ? IDLE : DROP) : imem_rvalid ? (id_stall ? HOLD : IDLE) : WAIT;
      HOLD: state_n = (flush || !id_stall) ? IDLE : HOLD;
      DROP: state_n = imem_rvalid ? IDLE : DROP;
    endcase
  end
  always_comb begin
    imem_req  = state == IDLE && en && !flush && !rst;
    imem_addr = pc_if;
    deliver   = !rst && !flush && !id_stall && ((state == WAIT && imem_rvalid) || state == HOLD);
    dlv_pc    = state == HOLD ? hold_pc : req_pc;
    dlv_inst  = state == HOLD ? hold_inst : imem_rdata;
    pc_stall  = !deliver;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc    <= RESET_PC;
      hold_pc   <= '0;
      hold_inst <= '0;
    end else begin
      if (imem_req && imem_ready) req_pc <= pc_if;
      if (state == WAIT && imem_rvalid && !flush && id_stall) begin
        hold_pc   <= req_pc;
        hold_inst <= imem_rdata;
      end
    end
  end
  // IF/ID priority: reset, flush, ID stall, delivery, bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc    <= RESET_PC;
      id_inst  <= NOP_INST;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
    end else if (!id_stall) begin
      id_valid <= deliver;
      id_pc    <= deliver ? dlv_pc : id_pc;
      id_inst  <= deliver ? dlv_inst : NOP_INST;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, directed corner sequences and randomized traffic against a transaction-level model
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst = 1, en = 0, flush = 0, imem_ready = 0, imem_rvalid = 0, id_stall = 0;
  logic [31:0] pc_if = 0, imem_rdata = 0;
  logic pc_stall, imem_req, id_valid;
  logic [31:0] imem_addr, id_pc, id_inst;
  int checks = 0, failures = 0;

  fetch_unit dut (.clk(clk), .rst(rst), .en(en), .pc_if(pc_if), .pc_stall(pc_stall), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .id_stall(id_stall), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst));

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] pc, inst;} ent_t;
  ent_t hq[$];
  bit m_busy = 0, m_disc = 0, acc_last = 0;
  logic [31:0] m_pend = 0;
  logic e_valid = 0;
  logic [31:0] e_pc = RPC, e_inst = NOP;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endtask

  // Model view: at most one request in flight (m_busy), optionally doomed by a flush (m_disc),
  // plus a queue of at most one instruction waiting for ID.
  task automatic tick_a();
    logic req_e, have;
    ent_t d;
    #1;
    req_e = !rst && en && !flush && !m_busy && hq.size() == 0;
    have = 0;
    d = '0;
    if (!rst && !flush && !id_stall) begin
      if (hq.size() != 0) begin have = 1; d = hq[0]; end
      else if (m_busy && !m_disc && imem_rvalid) begin have = 1; d = {m_pend, imem_rdata}; end
    end
    if (imem_rvalid && !rst && !m_busy) $display("protocol: rvalid with no request outstanding at %0t (ignored)", $time);
    chk("imem_req", imem_req, req_e);
    chk("pc_stall", pc_stall, !have);
    chk("imem_addr", imem_addr, pc_if);
    acc_last = req_e && imem_ready;
    if (rst) begin
      hq.delete(); m_busy = 0; m_disc = 0;
      e_valid = 0; e_pc = RPC; e_inst = NOP;
    end else begin
      if (flush) begin e_valid = 0; e_inst = NOP; end
      else if (!id_stall) begin
        e_valid = have;
        if (have) begin e_pc = d.pc; e_inst = d.inst; end else e_inst = NOP;
      end
      if (hq.size() != 0 && (flush || !id_stall)) hq.delete();
      if (m_busy) begin
        if (imem_rvalid) begin
          if (!m_disc && !flush && id_stall) hq.push_back({m_pend, imem_rdata});
          m_busy = 0; m_disc = 0;
        end else if (flush) m_disc = 1;
      end else if (acc_last) begin
        m_busy = 1; m_pend = pc_if;
      end
    end
  endtask

  task automatic tick_b();
    @(posedge clk); #1;
    chk("id_valid", id_valid, e_valid);
    chk("id_pc", id_pc, e_pc);
    chk("id_inst", id_inst, e_inst);
  endtask

  task automatic tick();
    tick_a(); tick_b();
  endtask

  task automatic drv(input logic e, input logic f, input logic s, input logic r, input logic v,
                     input logic [31:0] p, input logic [31:0] d);
    en = e; flush = f; id_stall = s; imem_ready = r; imem_rvalid = v; pc_if = p; imem_rdata = d;
  endtask

  typedef struct {
    logic en, flush, stall, ready, rvalid;
    logic [31:0] pc, rdata;
    logic req, pcs, valid;
    logic [31:0] epc, einst;
  } vec_t;
  vec_t v[8];

  initial begin
    int mem_lat;
    bit mem_pend;
    v[0] = '{1,0,0,1,0, 32'h0040_0000, 0,            1,1,0, RPC,           NOP};
    v[1] = '{1,0,0,1,1, 32'h0040_0000, 32'h0000_0093, 0,0,1, 32'h0040_0000, 32'h0000_0093};
    v[2] = '{1,0,0,1,0, 32'h0040_0004, 0,            1,1,0, 32'h0040_0000, NOP};
    v[3] = '{1,0,0,1,1, 32'h0040_0004, 32'h0010_0113, 0,0,1, 32'h0040_0004, 32'h0010_0113};
    v[4] = '{1,0,0,1,0, 32'h0040_0008, 0,            1,1,0, 32'h0040_0004, NOP};
    v[5] = '{1,0,0,1,1, 32'h0040_0008, 32'h0020_0193, 0,0,1, 32'h0040_0008, 32'h0020_0193};
    v[6] = '{1,0,0,1,0, 32'h0040_000C, 0,            1,1,0, 32'h0040_0008, NOP};
    v[7] = '{1,0,0,1,1, 32'h0040_000C, 32'h0030_0213, 0,0,1, 32'h0040_000C, 32'h0030_0213};
    // reset for two cycles, with junk on the memory response lines
    rst = 1; drv(1, 0, 0, 1, 1, 32'h1234_5678, 32'hDEAD_BEEF);
    tick(); tick();
    chk("rst_valid", id_valid, 1'b0); chk("rst_pc", id_pc, RPC); chk("rst_inst", id_inst, NOP);
    rst = 0;
    // fetch then stream four sequential PCs at one instruction per two cycles
    for (int i = 0; i < 8; i++) begin
      drv(v[i].en, v[i].flush, v[i].stall, v[i].ready, v[i].rvalid, v[i].pc, v[i].rdata);
      tick_a();
      chk("vec_req", imem_req, v[i].req); chk("vec_pc_stall", pc_stall, v[i].pcs);
      tick_b();
      chk("vec_valid", id_valid, v[i].valid); chk("vec_id_pc", id_pc, v[i].epc); chk("vec_inst", id_inst, v[i].einst);
    end
    // back-pressure: response lands while ID stalls, delivered from the buffer on release
    drv(1, 0, 0, 1, 0, 32'h0040_0010, 0); tick();
    drv(1, 0, 1, 1, 1, 32'h0040_0010, 32'hAAAA_0001); tick();
    chk("bp_valid", id_valid, 1'b0); chk("bp_pc", id_pc, 32'h0040_000C);
    for (int i = 0; i < 2; i++) begin
      drv(1, 0, 1, 1, 0, 32'h0040_0010, 0); tick_a();
      chk("bp_hold_pc_stall", pc_stall, 1'b1); chk("bp_hold_req", imem_req, 1'b0);
      tick_b();
    end
    drv(1, 0, 0, 1, 0, 32'h0040_0010, 0); tick_a();
    chk("bp_rel_pc_stall", pc_stall, 1'b0);
    tick_b();
    chk("bp_rel_valid", id_valid, 1'b1); chk("bp_rel_pc", id_pc, 32'h0040_0010); chk("bp_rel_inst", id_inst, 32'hAAAA_0001);
    // flush while outstanding: late response dropped, next request uses the redirected PC
    drv(1, 0, 0, 1, 0, 32'h0040_0014, 0); tick();
    drv(1, 1, 0, 1, 0, 32'h0040_0014, 0); tick();
    drv(1, 0, 0, 1, 0, 32'h0040_0100, 0); tick_a(); chk("drop_req", imem_req, 1'b0); tick_b();
    drv(1, 0, 0, 1, 1, 32'h0040_0100, 32'hDEAD_BEEF); tick_a(); chk("drop_rv_req", imem_req, 1'b0); tick_b();
    chk("drop_valid", id_valid, 1'b0); chk("drop_inst", id_inst, NOP);
    drv(1, 0, 0, 1, 0, 32'h0040_0100, 0); tick_a();
    chk("redir_req", imem_req, 1'b1); chk("redir_addr", imem_addr, 32'h0040_0100);
    tick_b();
    drv(1, 0, 0, 1, 1, 32'h0040_0100, 32'h1111_1111); tick();
    chk("redir_pc", id_pc, 32'h0040_0100); chk("redir_inst", id_inst, 32'h1111_1111);
    // flush coincident with response, then flush while holding
    drv(1, 0, 0, 1, 0, 32'h0040_0200, 0); tick();
    drv(1, 1, 0, 1, 1, 32'h0040_0200, 32'hDEAD_BEEF); tick();
    chk("fcoin_valid", id_valid, 1'b0); chk("fcoin_inst", id_inst, NOP);
    drv(1, 0, 0, 1, 0, 32'h0040_0204, 0); tick_a(); chk("fcoin_idle_req", imem_req, 1'b1); tick_b();
    drv(1, 0, 1, 1, 1, 32'h0040_0204, 32'h3333_3333); tick();
    drv(1, 1, 1, 1, 0, 32'h0040_0204, 0); tick();
    chk("fhold_valid", id_valid, 1'b0); chk("fhold_inst", id_inst, NOP);
    drv(1, 0, 0, 0, 0, 32'h0040_0208, 0); tick_a();
    chk("fhold_req", imem_req, 1'b1); chk("fhold_pc_stall", pc_stall, 1'b1);
    tick_b();
    chk("fhold_after_valid", id_valid, 1'b0);
    // en=0 mid-WAIT still delivers; reset mid-WAIT then a stray response
    drv(1, 0, 0, 1, 0, 32'h0040_0300, 0); tick();
    drv(0, 0, 0, 1, 0, 32'h0040_0300, 0); tick_a(); chk("en0_req", imem_req, 1'b0); tick_b();
    drv(0, 0, 0, 1, 1, 32'h0040_0300, 32'h2222_2222); tick_a();
    chk("en0_dlv_req", imem_req, 1'b0); chk("en0_dlv_pc_stall", pc_stall, 1'b0);
    tick_b();
    chk("en0_valid", id_valid, 1'b1); chk("en0_pc", id_pc, 32'h0040_0300); chk("en0_inst", id_inst, 32'h2222_2222);
    drv(0, 0, 0, 1, 0, 32'h0040_0304, 0); tick_a(); chk("en0_idle_req", imem_req, 1'b0); tick_b();
    drv(1, 0, 0, 1, 0, 32'h0040_0304, 0); tick();
    rst = 1; drv(1, 0, 0, 1, 0, 32'h0040_0304, 0); tick();
    chk("rstw_valid", id_valid, 1'b0); chk("rstw_pc", id_pc, RPC); chk("rstw_inst", id_inst, NOP);
    rst = 0; drv(0, 0, 0, 1, 1, 32'h0040_0304, 32'hDEAD_BEEF); tick();
    chk("late_valid", id_valid, 1'b0); chk("late_pc", id_pc, RPC); chk("late_inst", id_inst, NOP);
    drv(1, 0, 0, 0, 0, 32'h0040_0304, 0); tick_a(); chk("late_idle_req", imem_req, 1'b1); tick_b();
    // randomized traffic with a well-behaved variable-latency memory
    rst = 1; drv(0, 0, 0, 0, 0, 0, 0); tick(); rst = 0;
    mem_pend = 0; mem_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 63) == 0;
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 2) != 0, mem_pend && mem_lat == 0, $urandom << 2, $urandom);
      tick();
      if (rst || imem_rvalid) mem_pend = 0;
      else if (mem_pend) mem_lat--;
      if (acc_last) begin mem_pend = 1; mem_lat = $urandom_range(0, 2); end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage between the PC register and the decode stage.
- Takes the current fetch PC and issues one request at a time to a variable-latency instruction memory.
- Buffers the returned instruction and presents it to ID through the IF/ID segment registers.
- Drives the PC's stall input. Honours pipeline-wide flush (redirect) and ID back-pressure.

Parameters:
RESET_PC, 32'h0040_0000, reset value of id_pc; matches the PC reset vector.
NOP_INST, 32'h0000_0013, instruction presented on bubbles/reset (addi x0,x0,0).

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous active-high reset.
en  input  1  global run enable; 0 blocks new memory requests only.
pc_if  input  32  current PC register value.
pc_stall  output  1  to PC stall; 1 holds PC, 0 lets PC load npc.
flush  input  1  redirect/flush; same signal as the PC flush.
imem_req  output  1  request valid (combinational).
imem_addr  output  32  request address; equals pc_if.
imem_ready  input  1  memory accepts the request this cycle when imem_req and imem_ready are both 1.
imem_rvalid  input  1  response valid; in order; at most one outstanding.
imem_rdata  input  32  response instruction.
id_stall  input  1  ID cannot accept; IF/ID registers hold.
id_valid  output  1  IF/ID valid (registered).
id_pc  output  32  IF/ID PC (registered).
id_inst  output  32  IF/ID instruction (registered).

Behaviour:
- Reset: state=IDLE; id_valid=0; id_pc=RESET_PC; id_inst=NOP_INST; hold buffer cleared. rst overrides all other inputs, including mid-transaction. Any memory response arriving after reset with no request issued since reset is ignored (state IDLE).
- Internal registers: a one-entry hold buffer (inst, pc), and req_pc, which latches pc_if at acceptance.
- States: IDLE, WAIT, HOLD, DROP.
- imem_req = (state==IDLE) & en & ~flush & ~rst.
- pc_stall = 1 except in the delivering cycle (see below).
- IDLE:
  - if imem_req & imem_ready: req_pc<=pc_if; go to WAIT.
  - otherwise stay.
- WAIT:
  - flush & ~imem_rvalid -> DROP.
  - flush & imem_rvalid -> IDLE; response discarded.
  - imem_rvalid & ~id_stall -> deliver {req_pc, imem_rdata} to ID; pc_stall=0 this cycle; go to IDLE.
  - imem_rvalid & id_stall -> capture into hold buffer; go to HOLD.
- HOLD:
  - flush -> IDLE; buffer discarded.
  - ~id_stall -> deliver buffer to ID; pc_stall=0 this cycle; go to IDLE.
- DROP:
  - imem_rvalid -> IDLE; response discarded.
  - Further flushes keep the state at DROP.
- "Deliver" means id_valid<=1, id_pc<=pc, id_inst<=inst on the next edge.
- IF/ID update priority:
  - rst first.
  - flush next: id_valid<=0, id_inst<=NOP_INST.
  - id_stall next: all IF/ID registers hold.
  - delivery next.
  - otherwise bubble: id_valid<=0, id_inst<=NOP_INST, id_pc holds.
- pc_stall is 0 only in the delivery cycle and only when flush=0. During flush the PC takes its own flush path, so pc_stall is don't-care there, but it must be driven 1.
- Latency/throughput with zero-wait memory (rvalid the cycle after acceptance): request in cycle N, delivery edge at end of N+1, next request N+2. Sustained rate is 1 instruction per 2 cycles. Extra memory wait cycles add 1:1.
- en=0 blocks only new requests; WAIT, HOLD and DROP still complete. Delivery is allowed while en=0.
- imem_rvalid in IDLE or HOLD is a protocol violation. It is ignored; the bench must flag it.
- Hold buffer capacity is 1; it is never overwritten because no request is issued in HOLD.

Test Plan:
1. Reset then fetch: rst=1 for 2 cycles, then en=1, pc_if=0x0040_0000, ready=1, zero-wait memory returns 0x0000_0093 -> id_valid=1, id_pc=0x0040_0000, id_inst=0x0000_0093 after 2 cycles; pc_stall=0 for exactly 1 cycle.
2. Streaming: 4 sequential PCs 0x0040_0000..0x0040_000C, zero-wait memory -> 4 deliveries in 8 cycles, in order, each id_pc matching its instruction; id_valid toggles 1/0.
3. Back-pressure: id_stall=1 for 3 cycles while a response arrives -> state HOLD, ID registers unchanged, pc_stall=1. Release -> buffered instruction appears 1 edge later with correct req_pc.
4. Flush while outstanding: flush during WAIT with rvalid 2 cycles later (rdata=0xDEAD_BEEF) -> DROP; 0xDEAD_BEEF never reaches ID; id_valid=0; the next request is issued with the new pc_if.
5. Flush coincident with rvalid, and flush in HOLD -> data discarded, id_valid=0, state IDLE the next cycle.
6. en=0 mid-WAIT, then reset mid-WAIT -> outstanding response is still delivered while en=0, with no new imem_req. After rst, outputs return to reset values and a late rvalid is ignored.
